reg_status_table: RTL

Register Status Table (RST) for the Tomasulo-style dispatch path. It records, for each of the 32 architectural registers, whether a result is pending and which 5-bit tag will produce it. It sits directly downstream of the tag FIFO: the dispatch unit writes the tag popped from the FIFO against the destination register. Entries are released when the matching tag is broadcast on the common data bus (CDB), the same event that returns the tag to the FIFO via the retire bus.

---
 rtl/reg_status_table_if.sv | 39 +++
 rtl/reg_status_table.sv | 80 ++++++++
 2 files changed

// File: rtl/reg_status_table_if.sv
// rtl/reg_status_table_if.sv - lookup, dispatch, CDB and flush signals of the register status table
//
// Ports (slave = table side, master = dispatch/issue side):
//   Rs_Addr/Rt_Addr        source register lookup addresses
//   Rs_Tag/Rs_Valid        pending tag and pending flag for Rs_Addr (CDB bypassed)
//   Rt_Tag/Rt_Valid        pending tag and pending flag for Rt_Addr (CDB bypassed)
//   Dis_Wr_En/Dis_Rd_Addr/Dis_Tag  dispatch allocation of a tag to a destination register
//   Cdb_Valid/Cdb_Tag      common data bus result broadcast
//   Flush                  discard every pending entry
//   Busy_Count             registered number of pending entries
interface reg_status_table_if #(
    parameter int TAG_WIDTH = 5
);
    logic [4:0]           Rs_Addr;
    logic [4:0]           Rt_Addr;
    logic [TAG_WIDTH-1:0] Rs_Tag;
    logic                 Rs_Valid;
    logic [TAG_WIDTH-1:0] Rt_Tag;
    logic                 Rt_Valid;
    logic                 Dis_Wr_En;
    logic [4:0]           Dis_Rd_Addr;
    logic [TAG_WIDTH-1:0] Dis_Tag;
    logic                 Cdb_Valid;
    logic [TAG_WIDTH-1:0] Cdb_Tag;
    logic                 Flush;
    logic [5:0]           Busy_Count;

    modport slave (
        input  Rs_Addr, Rt_Addr, Dis_Wr_En, Dis_Rd_Addr, Dis_Tag,
               Cdb_Valid, Cdb_Tag, Flush,
        output Rs_Tag, Rs_Valid, Rt_Tag, Rt_Valid, Busy_Count
    );

    modport master (
        output Rs_Addr, Rt_Addr, Dis_Wr_En, Dis_Rd_Addr, Dis_Tag,
               Cdb_Valid, Cdb_Tag, Flush,
        input  Rs_Tag, Rs_Valid, Rt_Tag, Rt_Valid, Busy_Count
    );
endinterface

// File: rtl/reg_status_table.sv
// rtl/reg_status_table.sv - per-register pending-result tag table for Tomasulo dispatch
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; clears every entry and the busy count
//   bus    reg_status_table_if.slave: two combinational lookups with CDB bypass,
//          dispatch write, CDB clear, flush and registered Busy_Count
module reg_status_table #(
    parameter int NUM_REGS  = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    reg_status_table_if.slave    bus
);

    logic [NUM_REGS-1:0]  valid;
    logic [TAG_WIDTH-1:0] tag [NUM_REGS];
    logic [NUM_REGS-1:0]  next_valid;
    logic                 rs_cdb_hit;
    logic                 rt_cdb_hit;
    logic                 dis_write;

    function automatic logic [5:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [5:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            acc = acc + {5'b0, v[i]};
        end
        return acc;
    endfunction

    // Register 0 is hard-wired "ready": writes to it are dropped here so
    // its valid bit can never be set.
    assign dis_write = bus.Dis_Wr_En && (bus.Dis_Rd_Addr != 5'd0);

    // A result on the CDB this cycle counts as ready for the lookups, so
    // issue does not wait an extra cycle for the table clear.
    assign rs_cdb_hit = bus.Cdb_Valid && (tag[bus.Rs_Addr] == bus.Cdb_Tag);
    assign rt_cdb_hit = bus.Cdb_Valid && (tag[bus.Rt_Addr] == bus.Cdb_Tag);

    assign bus.Rs_Valid = valid[bus.Rs_Addr] && !rs_cdb_hit;
    assign bus.Rt_Valid = valid[bus.Rt_Addr] && !rt_cdb_hit;
    assign bus.Rs_Tag   = bus.Rs_Valid ? tag[bus.Rs_Addr] : '0;
    assign bus.Rt_Tag   = bus.Rt_Valid ? tag[bus.Rt_Addr] : '0;

    // CDB clear first, then the dispatch write so it wins on the same entry.
    always_comb begin
        next_valid = valid;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.Cdb_Valid && valid[i] && (tag[i] == bus.Cdb_Tag)) begin
                next_valid[i] = 1'b0;
            end
        end
        if (dis_write) begin
            next_valid[bus.Dis_Rd_Addr] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid          <= '0;
            bus.Busy_Count <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                tag[i] <= '0;
            end
        end else if (bus.Flush) begin
            // Tags are left in place; with valid cleared they are never observed.
            valid          <= '0;
            bus.Busy_Count <= '0;
        end else begin
            valid          <= next_valid;
            bus.Busy_Count <= popcount(next_valid);
            if (dis_write) begin
                tag[bus.Dis_Rd_Addr] <= bus.Dis_Tag;
            end
        end
    end

endmodule
